// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: loads a length-prefixed byte stream into instruction memory, then runs the CPU until halt.
// Optional trailing XOR checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module cpu_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [15:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  input  logic              cpu_halt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  cycle_count_o
);
  // Accepting states are kept first so rx_ready decodes as state < RELEASE.
  typedef enum logic [3:0] {
    IDLE, LEN_LO, DATA_HI, DATA_LO,
`ifdef BOOT_CHECKSUM_EN
    CSUM,
`endif
    RELEASE, RUN, DONE, ERR
  } state_t;
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);
  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, hi_q;
  logic [15:0]       len_q, len_in;
  logic [ADDR_W-1:0] idx_q;
  logic              acc, last;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif
  assign acc    = rx_valid_i && rx_ready_o;
  assign len_in = {len_hi_q, rx_data_i};
  assign last   = 16'(idx_q) == len_q - 16'd1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = LEN_LO;
      LEN_LO:  if (acc) state_d = (len_in == 16'd0 || {1'b0, len_in} > MAX_LEN) ? ERR : DATA_HI;
      DATA_HI: if (acc) state_d = DATA_LO;
`ifdef BOOT_CHECKSUM_EN
      DATA_LO: if (acc) state_d = last ? CSUM : DATA_HI;
      CSUM:    if (acc) state_d = (rx_data_i == xor_q) ? RELEASE : ERR;
`else
      DATA_LO: if (acc) state_d = last ? RELEASE : DATA_HI;
`endif
      RELEASE: state_d = RUN;
      RUN:     if (cpu_halt_i) state_d = DONE;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_hi_q      <= '0;
      hi_q          <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      rx_ready_o    <= 1'b0;
      imem_we_o     <= 1'b0;
      imem_addr_o   <= '0;
      imem_wdata_o  <= '0;
      cpu_reset_o   <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      cycle_count_o <= '0;
`ifdef BOOT_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rx_ready_o  <= state_d < RELEASE;
      busy_o      <= !(state_d inside {IDLE, DONE, ERR});
      done_o      <= state_d == DONE;
      err_o       <= state_d == ERR;
      cpu_reset_o <= !(state_d inside {RUN, DONE});
      imem_we_o   <= acc && state_q == DATA_LO;
      if (acc && state_q == IDLE) len_hi_q <= rx_data_i;
      if (acc && state_q == LEN_LO) begin
        len_q <= len_in;
        idx_q <= '0;
      end
      if (acc && state_q == DATA_HI) hi_q <= rx_data_i;
      if (acc && state_q == DATA_LO) begin
        imem_addr_o  <= idx_q;
        imem_wdata_o <= {hi_q, rx_data_i};
        idx_q        <= idx_q + 1'b1;
      end
`ifdef BOOT_CHECKSUM_EN
      if (acc && state_q == LEN_LO) xor_q <= '0;
      if (acc && (state_q == DATA_HI || state_q == DATA_LO)) xor_q <= xor_q ^ rx_data_i;
`endif
      if (state_q == RUN && !cpu_halt_i && cycle_count_o != '1) cycle_count_o <= cycle_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader: directed, table-driven checks of the boot loader (length, load, run, reset, checksum).
module tb_cpu_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        rx_ready, imem_we, cpu_reset, busy, done, err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata, cycle_count;
  int          checks = 0;
  int          failures = 0;
  int          we_cnt = 0;
  logic [15:0] mem [256];
  logic [15:0] words [$];

  typedef struct {
    logic [15:0] len;
    logic        exp_err;
  } len_vec_t;
  len_vec_t lv [5];

  cpu_boot_loader #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_reset_o(cpu_reset), .cpu_halt_i(cpu_halt),
    .busy_o(busy), .done_o(done), .err_o(err), .cycle_count_o(cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && imem_we === 1'b1) begin
    mem[imem_addr] = imem_wdata;
    we_cnt = we_cnt + 1;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic chk_reset_vals(input string n);
    chk(n, {18'd0, rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err, cycle_count},
        {18'd0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
  endtask

  task automatic clear_log();
    we_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    cpu_halt = 1'b0;
    #1 chk_reset_vals("reset_async");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit ok;
    int t;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
      t++;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept byte=%0h", b);
    end
  endtask

  task automatic load(input bit gap);
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    send(8'(words.size() >> 8), gap);
    send(8'(words.size()), gap);
    foreach (words[i]) begin
      send(words[i][15:8], gap);
      send(words[i][7:0], gap);
`ifdef BOOT_CHECKSUM_EN
      x = x ^ words[i][15:8] ^ words[i][7:0];
`endif
    end
`ifdef BOOT_CHECKSUM_EN
    send(x, gap);
`endif
  endtask

  task automatic check_release_then_run(input string n);
    chk({n, "_release_rst"}, {63'd0, cpu_reset}, 64'd1);
    chk({n, "_release_busy"}, {63'd0, busy}, 64'd1);
    chk({n, "_release_ready"}, {63'd0, rx_ready}, 64'd0);
    @(posedge clk); #1;
    chk({n, "_run_rst"}, {63'd0, cpu_reset}, 64'd0);
    chk({n, "_run_busy"}, {63'd0, busy}, 64'd1);
    chk({n, "_run_we"}, {63'd0, imem_we}, 64'd0);
  endtask

  initial begin
    lv[0] = '{16'h0000, 1'b1};
    lv[1] = '{16'h0101, 1'b1};
    lv[2] = '{16'hFFFF, 1'b1};
    lv[3] = '{16'h0100, 1'b0};
    lv[4] = '{16'h0001, 1'b0};
    clear_log();
    rst_n = 1'b0;
    #7 chk_reset_vals("reset_init");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {63'd0, rx_ready}, 64'd1);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // N=3 load, back-to-back bytes
    words = '{16'h1234, 16'hABCD, 16'h0001};
    load(1'b0);
`ifndef BOOT_CHECKSUM_EN
    chk("last_we_pulse", {63'd0, imem_we}, 64'd1);
`endif
    chk("last_addr", {56'd0, imem_addr}, 64'd2);
    chk("last_wdata", {48'd0, imem_wdata}, 64'h0001);
    check_release_then_run("load3");
    chk("load3_we_cnt", 64'(we_cnt), 64'd3);
    chk("load3_mem0", {48'd0, mem[0]}, 64'h1234);
    chk("load3_mem1", {48'd0, mem[1]}, 64'hABCD);
    chk("load3_mem2", {48'd0, mem[2]}, 64'h0001);
    repeat (25) @(posedge clk);
    #1 chk("run25_count", {48'd0, cycle_count}, 64'd25);
    chk("run25_done", {63'd0, done}, 64'd0);
    cpu_halt = 1'b1;
    @(posedge clk); #1;
    cpu_halt = 1'b0;
    chk("halt_count", {48'd0, cycle_count}, 64'd25);
    chk("halt_done", {63'd0, done}, 64'd1);
    chk("halt_busy", {63'd0, busy}, 64'd0);
    chk("halt_ready", {63'd0, rx_ready}, 64'd0);
    chk("halt_err", {63'd0, err}, 64'd0);
    chk("halt_cpu_rst", {63'd0, cpu_reset}, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("done_count_frozen", {48'd0, cycle_count}, 64'd25);

    // length table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      send(lv[i].len[15:8], 1'b0);
      send(lv[i].len[7:0], 1'b0);
      chk($sformatf("len%0h_err", lv[i].len), {63'd0, err}, {63'd0, lv[i].exp_err});
      chk($sformatf("len%0h_busy", lv[i].len), {63'd0, busy}, {63'd0, !lv[i].exp_err});
      chk($sformatf("len%0h_ready", lv[i].len), {63'd0, rx_ready}, {63'd0, !lv[i].exp_err});
      repeat (3) @(posedge clk);
      #1 chk($sformatf("len%0h_cpu_rst", lv[i].len), {63'd0, cpu_reset}, 64'd1);
      chk($sformatf("len%0h_no_we", lv[i].len), 64'(we_cnt), 64'd0);
      chk($sformatf("len%0h_done", lv[i].len), {63'd0, done}, 64'd0);
    end

    // valid toggling 1-0-1 with cpu_halt held high through the load
    do_reset();
    cpu_halt = 1'b1;
    load(1'b1);
    cpu_halt = 1'b0;
    check_release_then_run("toggle");
    chk("toggle_we_cnt", 64'(we_cnt), 64'd3);
    chk("toggle_mem0", {48'd0, mem[0]}, 64'h1234);
    chk("toggle_mem1", {48'd0, mem[1]}, 64'hABCD);
    chk("toggle_mem2", {48'd0, mem[2]}, 64'h0001);
    chk("toggle_not_done", {63'd0, done}, 64'd0);
    repeat (4) @(posedge clk);
    #1 chk("toggle_count4", {48'd0, cycle_count}, 64'd4);

    // async reset in the middle of word 2 of 4, then a clean N=1 load
    do_reset();
    send(8'h00, 1'b0);
    send(8'h04, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("midload_we_cnt", 64'(we_cnt), 64'd1);
    do_reset();
    words = '{16'hBEEF};
    load(1'b0);
    check_release_then_run("beef");
    chk("beef_we_cnt", 64'(we_cnt), 64'd1);
    chk("beef_mem0", {48'd0, mem[0]}, 64'hBEEF);
    chk("beef_mem1_untouched", {48'd0, mem[1]}, 64'h0000);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    words = '{16'h1122, 16'h3344};
    load(1'b0);
    check_release_then_run("csum_ok");
    chk("csum_ok_err", {63'd0, err}, 64'd0);
    do_reset();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h45, 1'b0);
    chk("csum_bad_err", {63'd0, err}, 64'd1);
    chk("csum_bad_done", {63'd0, done}, 64'd0);
    chk("csum_bad_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("csum_bad_cpu_rst", {63'd0, cpu_reset}, 64'd1);
    chk("csum_bad_we_cnt", 64'(we_cnt), 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
